// File: rtl/mdma_80bx512_ram_fifo_if.sv
// Stream and RAM-port bundle for the MDMA 80b x 512 RAM FIFO.
// The master modport is the FIFO controller side; slave is the producer/consumer/RAM side.
interface mdma_80bx512_ram_fifo_if #(
  parameter int AW = 9,
  parameter int DW = 80
);
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_dat;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;
  logic          out_sbe;
  logic          out_dbe;
  logic [AW-1:0] ram_wadr;
  logic          ram_wen;
  logic [DW-1:0] ram_wdat;
  logic          ram_ren;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdat;
  logic          ram_rsbe;
  logic          ram_rdbe;

  modport master (
    input  in_vld, in_dat, out_rdy, ram_rdat, ram_rsbe, ram_rdbe,
    output in_rdy, out_vld, out_dat, out_sbe, out_dbe,
    output ram_wadr, ram_wen, ram_wdat, ram_ren, ram_radr
  );

  modport slave (
    output in_vld, in_dat, out_rdy, ram_rdat, ram_rsbe, ram_rdbe,
    input  in_rdy, out_vld, out_dat, out_sbe, out_dbe,
    input  ram_wadr, ram_wen, ram_wdat, ram_ren, ram_radr
  );
endinterface

// File: rtl/mdma_80bx512_ram_fifo.sv
// FIFO controller mastering an 80b x 512 ECC RAM; reads are credit-prefetched into a
// small buffer so the output side sustains one word per cycle with ECC flags attached.
module mdma_80bx512_ram_fifo #(
  parameter int DEPTH    = 512,
  parameter int AW       = 9,
  parameter int DW       = 80,
  parameter int RD_LAT   = 2,
  parameter int PF_DEPTH = 4,
  parameter int CW       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mdma_80bx512_ram_fifo_if.master bus,
  output logic [AW+3:0]           occupancy,
  output logic [CW-1:0]           sbe_cnt,
  output logic [CW-1:0]           dbe_cnt
);
  localparam int PW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int NW = $clog2(PF_DEPTH + 1);
  localparam int OW = AW + 4;

  logic              run_q;
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       ram_cnt_q;
  logic [AW:0]       ram_cnt_d;
  logic [NW-1:0]     inflight_q;
  logic [NW-1:0]     inflight_d;
  logic [NW-1:0]     pf_cnt_q;
  logic [NW-1:0]     pf_cnt_d;
  logic [RD_LAT-1:0] rd_vld_p;
  logic [PW-1:0]     pf_head_q;
  logic [PW-1:0]     pf_tail_q;
  logic [DW+1:0]     pf_mem [PF_DEPTH];
  logic [DW+1:0]     pf_head_ent;
  logic [OW-1:0]     occ_d;
  logic              in_rdy;
  logic              acc;
  logic              ren;
  logic              ret;
  logic              out_vld;
  logic              pop;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return (en && !(&v)) ? v + CW'(1) : v;
  endfunction

  function automatic logic [PW-1:0] pf_next(input logic [PW-1:0] p);
    return (p == PW'(PF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue: a read is only launched when a prefetch slot is guaranteed for its return
  always_comb begin
    in_rdy     = run_q && (ram_cnt_q != (AW+1)'(DEPTH));
    acc        = bus.in_vld && in_rdy;
    ren        = (ram_cnt_q != '0) &&
                 (((NW+1)'(inflight_q) + (NW+1)'(pf_cnt_q)) < (NW+1)'(PF_DEPTH));
    ret        = rd_vld_p[RD_LAT-1];
    out_vld    = (pf_cnt_q != '0);
    pop        = out_vld && bus.out_rdy;
    ram_cnt_d  = ram_cnt_q + (AW+1)'(acc) - (AW+1)'(ren);
    inflight_d = inflight_q + NW'(ren) - NW'(ret);
    pf_cnt_d   = pf_cnt_q + NW'(ret) - NW'(pop);
    occ_d      = OW'(ram_cnt_d) + OW'(inflight_d) + OW'(pf_cnt_d);
  end

  always_comb begin
    pf_head_ent  = pf_mem[pf_head_q];
    bus.in_rdy   = in_rdy;
    bus.ram_wen  = acc;
    bus.ram_wadr = wptr_q;
    bus.ram_wdat = acc ? bus.in_dat : '0;
    bus.ram_ren  = ren;
    bus.ram_radr = rptr_q;
    bus.out_vld  = out_vld;
    bus.out_dat  = out_vld ? pf_head_ent[DW+1:2] : '0;
    bus.out_sbe  = out_vld && pf_head_ent[1];
    bus.out_dbe  = out_vld && pf_head_ent[0];
  end

  // Control state: pointers, counts, and the read-return valid pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= '0;
      pf_cnt_q   <= '0;
      rd_vld_p   <= '0;
      pf_head_q  <= '0;
      pf_tail_q  <= '0;
      occupancy  <= '0;
      sbe_cnt    <= '0;
      dbe_cnt    <= '0;
    end else begin
      run_q      <= 1'b1;
      if (acc) wptr_q <= wptr_q + AW'(1);
      if (ren) rptr_q <= rptr_q + AW'(1);
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      pf_cnt_q   <= pf_cnt_d;
      rd_vld_p   <= RD_LAT'({rd_vld_p, ren});
      if (ret) pf_tail_q <= pf_next(pf_tail_q);
      if (pop) pf_head_q <= pf_next(pf_head_q);
      occupancy  <= occ_d;
      sbe_cnt    <= sat_inc(sbe_cnt, pop && pf_head_ent[1]);
      dbe_cnt    <= sat_inc(dbe_cnt, pop && pf_head_ent[0]);
    end
  end

  // Return stage: RAM data and flags land in the prefetch buffer
  always_ff @(posedge clk) begin
    if (ret) pf_mem[pf_tail_q] <= {bus.ram_rdat, bus.ram_rsbe, bus.ram_rdbe};
  end
endmodule

// File: tb/tb_mdma_80bx512_ram_fifo.sv
// Scoreboard bench for mdma_80bx512_ram_fifo with a behavioural 2-cycle ECC RAM model
// whose error flags are keyed on a marker in the stored word's top byte.
module tb_mdma_80bx512_ram_fifo;
  localparam int DEPTH = 512, AW = 9, DW = 80, RD_LAT = 2, PF_DEPTH = 4, CW = 16;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sbe;
    logic          dbe;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW+3:0] occupancy;
  logic [CW-1:0] sbe_cnt;
  logic [CW-1:0] dbe_cnt;

  mdma_80bx512_ram_fifo_if #(.AW(AW), .DW(DW)) bus ();

  mdma_80bx512_ram_fifo #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PF_DEPTH(PF_DEPTH), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .occupancy(occupancy),
    .sbe_cnt(sbe_cnt),
    .dbe_cnt(dbe_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: write on wen, read data appears RD_LAT cycles after ren
  logic [DW-1:0] mem [DEPTH];
  logic [DW+1:0] rd_s0, rd_s1;

  function automatic logic [1:0] inj(input logic [DW-1:0] d);
    logic [7:0] t;
    t = d[DW-1 -: 8];
    return {(t == 8'hE1) || (t == 8'hE3), (t == 8'hE2) || (t == 8'hE3)};
  endfunction

  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_wadr] <= bus.ram_wdat;
    if (bus.ram_ren) rd_s0 <= {mem[bus.ram_radr], inj(mem[bus.ram_radr])};
    rd_s1 <= rd_s0;
  end
  assign bus.ram_rdat = rd_s1[DW+1:2];
  assign bus.ram_rsbe = rd_s1[1];
  assign bus.ram_rdbe = rd_s1[0];

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   model_occ = 0;
  int   rdy_mode = 0;
  int   bub_chk = 0;
  int   bubbles = 0;
  int   max_occ = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  function automatic logic [DW-1:0] mkd(input logic [7:0] top, input int v);
    return {top, 72'(v)};
  endfunction

  // Consumer ready: 0 = hold low, 1 = always, 2 = 50% random
  initial begin
    bus.out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_rdy = 1'b0;
        1:       bus.out_rdy = 1'b1;
        default: bus.out_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected words on every transfer and tracks occupancy every cycle
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_occ = 0;
    end else begin
      check("occupancy", 128'(occupancy), 128'(model_occ));
      if (bub_chk != 0) begin
        if (!bus.out_vld) bubbles++;
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      end
      if (bus.out_vld && bus.out_rdy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_word: got %h want nothing", bus.out_dat);
        end else begin
          mon_e = sb.pop_front();
          check("out_dat", 128'(bus.out_dat), 128'(mon_e.dat));
          check("out_sbe", 128'(bus.out_sbe), 128'(mon_e.sbe));
          check("out_dbe", 128'(bus.out_dbe), 128'(mon_e.dbe));
        end
      end
      model_occ = model_occ + ((bus.in_vld && bus.in_rdy) ? 1 : 0)
                            - ((bus.out_vld && bus.out_rdy) ? 1 : 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; push its expectation on acceptance. Starts and ends at posedge+1.
  task automatic send(input logic [DW-1:0] d, input logic s, input logic b);
    exp_t e;
    bit   done;
    done = 1'b0;
    bus.in_vld = 1'b1;
    bus.in_dat = d;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        e.dat = d;
        e.sbe = s;
        e.dbe = b;
        sb.push_back(e);
        done = 1'b1;
      end
      drv();
    end
    if (!done) check("send_accept", 128'(0), 128'(1));
    bus.in_vld = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int k = 0; k < lim && sb.size() != 0; k++) drv();
    check("drain_empty", 128'(sb.size()), 128'(0));
  endtask

  int            n_acc;
  int            idle;
  int            first;
  int            seq;
  int            stale;
  bit            got;
  logic [DW-1:0] fd;

  initial begin
    bus.in_vld = 1'b0;
    bus.in_dat = '0;
    seq = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", 128'(bus.in_rdy), 128'(0));
    check("rst_out_vld", 128'(bus.out_vld), 128'(0));
    check("rst_ram_wen", 128'(bus.ram_wen), 128'(0));
    check("rst_ram_ren", 128'(bus.ram_ren), 128'(0));
    check("rst_occ", 128'(occupancy), 128'(0));
    drv();
    rst = 1'b0;
    @(negedge clk);
    check("in_rdy_before_edge", 128'(bus.in_rdy), 128'(0));

    // Single word latency: wen at T, ren at T+1, out at T+4, empty at T+5
    drv();
    rdy_mode = 1;
    bus.in_vld = 1'b1;
    bus.in_dat = 80'h1234;
    @(negedge clk);
    check("in_rdy_after_edge", 128'(bus.in_rdy), 128'(1));
    check("t0_ram_wen", 128'(bus.ram_wen), 128'(1));
    check("t0_ram_wadr", 128'(bus.ram_wadr), 128'(0));
    check("t0_ram_wdat", 128'(bus.ram_wdat), 128'(80'h1234));
    begin
      exp_t e0;
      e0.dat = 80'h1234;
      e0.sbe = 1'b0;
      e0.dbe = 1'b0;
      sb.push_back(e0);
    end
    drv();
    bus.in_vld = 1'b0;
    @(negedge clk);
    check("t1_ram_ren", 128'(bus.ram_ren), 128'(1));
    check("t1_ram_radr", 128'(bus.ram_radr), 128'(0));
    for (int k = 2; k < 4; k++) begin
      drv();
      @(negedge clk);
      check("t2_t3_out_vld", 128'(bus.out_vld), 128'(0));
    end
    drv();
    @(negedge clk);
    check("t4_out_vld", 128'(bus.out_vld), 128'(1));
    check("t4_out_dat", 128'(bus.out_dat), 128'(80'h1234));
    drv();
    @(negedge clk);
    check("t5_occ", 128'(occupancy), 128'(0));
    drv();

    // Streaming 2000 words, no bubbles once the pipeline has filled
    bubbles = 0;
    max_occ = 0;
    for (int i = 0; i < 2000; i++) begin
      send(mkd(8'h00, 256 + i), 1'b0, 1'b0);
      if (i == 3) bub_chk = 1;
    end
    bub_chk = 0;
    drain(100);
    check("stream_bubbles", 128'(bubbles), 128'(0));
    check("stream_occ_bound", 128'(max_occ <= PF_DEPTH + 2), 128'(1));

    // Fill with consumer stalled: 512 in RAM plus 4 prefetched
    rdy_mode = 0;
    n_acc = 0;
    idle = 0;
    seq = 5000;
    bus.in_vld = 1'b1;
    bus.in_dat = mkd(8'h00, seq);
    for (int k = 0; k < 800 && idle < 8; k++) begin
      got = 1'b0;
      @(negedge clk);
      if (bus.in_rdy) begin
        sb.push_back('{dat: bus.in_dat, sbe: 1'b0, dbe: 1'b0});
        n_acc++;
        idle = 0;
        got = 1'b1;
      end else begin
        idle++;
      end
      drv();
      if (got) begin
        seq++;
        bus.in_dat = mkd(8'h00, seq);
      end
    end
    check("fill_count", 128'(n_acc), 128'(516));
    @(negedge clk);
    check("fill_occ", 128'(occupancy), 128'(516));
    drv();

    // One pop frees exactly one slot, visible on in_rdy within 2 cycles
    rdy_mode = 1;
    n_acc = 0;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      got = 1'b0;
      @(negedge clk);
      if (bus.in_rdy) begin
        sb.push_back('{dat: bus.in_dat, sbe: 1'b0, dbe: 1'b0});
        n_acc++;
        if (first < 0) first = k;
        got = 1'b1;
      end
      drv();
      if (k == 0) rdy_mode = 0;
      if (got) begin
        seq++;
        bus.in_dat = mkd(8'h00, seq);
      end
    end
    bus.in_vld = 1'b0;
    check("refill_count", 128'(n_acc), 128'(1));
    check("refill_latency", 128'((first >= 1) && (first <= 2)), 128'(1));
    @(negedge clk);
    check("refill_occ", 128'(occupancy), 128'(516));
    drv();
    rdy_mode = 1;
    drain(700);

    // ECC flags: 3rd word single-bit, 7th word double-bit, flow uninterrupted
    bubbles = 0;
    for (int i = 0; i < 10; i++) begin
      send(mkd((i == 2) ? 8'hE1 : (i == 6) ? 8'hE2 : 8'h00, 9000 + i), i == 2, i == 6);
      if (i == 3) bub_chk = 1;
    end
    bub_chk = 0;
    drain(50);
    check("ecc_bubbles", 128'(bubbles), 128'(0));
    check("sbe_cnt_1", 128'(sbe_cnt), 128'(1));
    check("dbe_cnt_1", 128'(dbe_cnt), 128'(1));
    send(mkd(8'hE3, 9100), 1'b1, 1'b1);
    drain(50);
    check("sbe_cnt_2", 128'(sbe_cnt), 128'(2));
    check("dbe_cnt_2", 128'(dbe_cnt), 128'(2));

    // Random producer gaps and consumer stalls
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 1) drv();
      send({16'h0000, 32'($urandom), 32'(i)}, 1'b0, 1'b0);
    end
    rdy_mode = 1;
    drain(700);

    // Reset with 300 words stored and reads in flight
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) send(mkd(8'h00, 20000 + i), 1'b0, 1'b0);
    rdy_mode = 1;
    repeat (3) drv();
    rst = 1'b1;
    #1;
    check("mid_rst_in_rdy", 128'(bus.in_rdy), 128'(0));
    check("mid_rst_out_vld", 128'(bus.out_vld), 128'(0));
    check("mid_rst_out_dat", 128'(bus.out_dat), 128'(0));
    check("mid_rst_out_flags", 128'({bus.out_sbe, bus.out_dbe}), 128'(0));
    check("mid_rst_ram_ren", 128'(bus.ram_ren), 128'(0));
    check("mid_rst_ram_wen", 128'(bus.ram_wen), 128'(0));
    check("mid_rst_ram_wadr", 128'(bus.ram_wadr), 128'(0));
    check("mid_rst_ram_radr", 128'(bus.ram_radr), 128'(0));
    check("mid_rst_occ", 128'(occupancy), 128'(0));
    check("mid_rst_sbe_cnt", 128'(sbe_cnt), 128'(0));
    check("mid_rst_dbe_cnt", 128'(dbe_cnt), 128'(0));
    drv();
    drv();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy_0", 128'(bus.in_rdy), 128'(0));
    drv();
    @(negedge clk);
    check("post_rst_in_rdy_1", 128'(bus.in_rdy), 128'(1));
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      drv();
      @(negedge clk);
      if (bus.out_vld || bus.ram_ren || (occupancy != '0)) stale++;
    end
    check("post_rst_stale", 128'(stale), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
